// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if
// Instruction-memory request/response bundle between the fetch unit and memory.
//   req    : fetch unit -> memory, request valid, held until gnt
//   addr   : fetch unit -> memory, request address
//   gnt    : memory -> fetch unit, request accepted
//   rvalid : memory -> fetch unit, read data valid
//   rdata  : memory -> fetch unit, read data
interface pc_fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, output addr, input gnt, input rvalid, input rdata);
    modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// Holds the architectural PC and fetches the instruction at PC over a
// req/gnt/rvalid memory port, then hands it to decode until accepted.
// Ports:
//   clk, rst_n     : clock (rising edge), async active-low reset
//   npc_i          : next PC, taken when the core accepts the instruction
//   pc_o           : current PC
//   inst_o         : fetched instruction (NOP_INST while not valid)
//   inst_valid_o   : inst_o valid for pc_o
//   inst_ready_i   : core accepts inst_o (only honoured while holding)
//   imem           : instruction-memory bundle (master side)
//   retire_cnt_o   : number of accepted instructions (wraps)
//   misalign_o     : sticky misaligned next-PC flag
// Optional feature macro: IFU_MISALIGN_CHK_EN
//   defined   : a misaligned npc_i on accept parks the unit in S_ERR
//   undefined : npc_i is force-aligned, misalign_o is constant 0
//
// state  | meaning
// S_IDLE | first cycle after reset, no request yet
// S_REQ  | request driven, waiting for gnt
// S_WAIT | granted, waiting for rvalid
// S_HOLD | instruction valid, waiting for core accept
// S_ERR  | misaligned next PC seen, stuck until reset
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [31:0]            npc_i,
    output logic [31:0]            pc_o,
    output logic [31:0]            inst_o,
    output logic                   inst_valid_o,
    input  logic                   inst_ready_i,
    pc_fetch_unit_if.master        imem,
    output logic [31:0]            retire_cnt_o,
    output logic                   misalign_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_inst, w_inst_nxt;
    logic        r_valid, w_valid_nxt;
    logic [31:0] r_retire_cnt, w_retire_nxt;
`ifdef IFU_MISALIGN_CHK_EN
    logic        r_misalign, w_misalign_nxt;
`else
    // Low bits of npc_i are dropped by force-alignment in this build.
    logic [1:0]  w_unused_npc_lsb;
    assign w_unused_npc_lsb = npc_i[1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_inst       <= NOP_INST;
            r_valid      <= 1'b0;
            r_retire_cnt <= 32'd0;
`ifdef IFU_MISALIGN_CHK_EN
            r_misalign   <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_inst       <= w_inst_nxt;
            r_valid      <= w_valid_nxt;
            r_retire_cnt <= w_retire_nxt;
`ifdef IFU_MISALIGN_CHK_EN
            r_misalign   <= w_misalign_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_inst_nxt   = r_inst;
        w_valid_nxt  = r_valid;
        w_retire_nxt = r_retire_cnt;
`ifdef IFU_MISALIGN_CHK_EN
        w_misalign_nxt = r_misalign;
`endif
        case (r_state)
            S_IDLE: w_state_nxt = S_REQ;
            S_REQ: begin
                if (imem.gnt) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // Only reachable one cycle after gnt, so rvalid in the gnt cycle is never taken.
                if (imem.rvalid) begin
                    w_inst_nxt  = imem.rdata;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (inst_ready_i) begin
                    w_retire_nxt = r_retire_cnt + 32'd1;
                    w_valid_nxt  = 1'b0;
                    w_inst_nxt   = NOP_INST;
`ifdef IFU_MISALIGN_CHK_EN
                    if (npc_i[1:0] != 2'b00) begin
                        w_misalign_nxt = 1'b1;
                        w_state_nxt    = S_ERR;
                    end else begin
                        w_pc_nxt    = npc_i;
                        w_state_nxt = S_REQ;
                    end
`else
                    w_pc_nxt    = {npc_i[31:2], 2'b00};
                    w_state_nxt = S_REQ;
`endif
                end
            end
            S_ERR:   w_state_nxt = S_ERR;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign imem.req     = (r_state == S_REQ);
    assign imem.addr    = r_pc;
    assign pc_o         = r_pc;
    assign inst_o       = r_inst;
    assign inst_valid_o = r_valid;
    assign retire_cnt_o = r_retire_cnt;
`ifdef IFU_MISALIGN_CHK_EN
    assign misalign_o   = r_misalign;
`else
    assign misalign_o   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic [31:0] npc_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] retire_cnt_o;
    logic        misalign_o;

    pc_fetch_unit_if imem_bus ();

    pc_fetch_unit #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .npc_i        (npc_i),
        .pc_o         (pc_o),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o),
        .inst_ready_i (inst_ready_i),
        .imem         (imem_bus.master),
        .retire_cnt_o (retire_cnt_o),
        .misalign_o   (misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // reference model: architectural PC and retire count
    logic [31:0] m_pc;
    logic [31:0] m_retire;
    bit          m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full instruction fetch starting in the request phase.
    task automatic fetch_one(input int gdly, input int rdly, input int hdly,
                             input logic [31:0] data, input logic [31:0] npc, input bit preset);
        logic [31:0] junk;
        junk = ~data;
        chk("req_start", imem_bus.req, 1);
        chk("addr_start", imem_bus.addr, m_pc);
        for (int i = 0; i < gdly; i++) begin
            imem_bus.gnt    = 1'b0;
            imem_bus.rvalid = 1'($urandom_range(0, 1));
            imem_bus.rdata  = junk;
            inst_ready_i    = 1'($urandom_range(0, 1));
            step();
            chk("req_held", imem_bus.req, 1);
            chk("addr_held", imem_bus.addr, m_pc);
            chk("valid_in_req", inst_valid_o, 0);
        end
        // stray rvalid may coincide with gnt; it must not be captured
        imem_bus.gnt    = 1'b1;
        imem_bus.rvalid = 1'($urandom_range(0, 1));
        imem_bus.rdata  = junk;
        inst_ready_i    = 1'($urandom_range(0, 1));
        step();
        imem_bus.gnt    = 1'b0;
        chk("req_after_gnt", imem_bus.req, 0);
        chk("valid_after_gnt", inst_valid_o, 0);
        for (int i = 0; i < rdly; i++) begin
            imem_bus.rvalid = 1'b0;
            inst_ready_i    = 1'($urandom_range(0, 1));
            step();
            chk("valid_wait", inst_valid_o, 0);
            chk("req_wait", imem_bus.req, 0);
            chk("retire_wait", retire_cnt_o, m_retire);
        end
        imem_bus.rvalid = 1'b1;
        imem_bus.rdata  = data;
        inst_ready_i    = 1'($urandom_range(0, 1));
        step();
        imem_bus.rvalid = 1'b0;
        imem_bus.rdata  = junk;
        inst_ready_i    = 1'b0;
        chk("valid_hold", inst_valid_o, 1);
        chk("inst_hold", inst_o, data);
        chk("pc_hold", pc_o, m_pc);
        chk("retire_hold", retire_cnt_o, m_retire);
        if (preset) begin
            force dut.r_retire_cnt = 32'hFFFF_FFFF;
            #1;
            release dut.r_retire_cnt;
            m_retire = 32'hFFFF_FFFF;
            chk("retire_preset", retire_cnt_o, m_retire);
        end
        for (int i = 0; i < hdly; i++) begin
            inst_ready_i = 1'b0;
            npc_i        = $urandom;
            step();
            chk("valid_bp", inst_valid_o, 1);
            chk("inst_bp", inst_o, data);
            chk("pc_bp", pc_o, m_pc);
            chk("req_bp", imem_bus.req, 0);
        end
        inst_ready_i = 1'b1;
        npc_i        = npc;
        step();
        inst_ready_i = 1'b0;
        m_retire     = m_retire + 32'd1;
`ifdef IFU_MISALIGN_CHK_EN
        if (npc[1:0] != 2'b00) m_err = 1'b1;
`endif
        if (m_err) begin
            chk("misalign_set", misalign_o, 1);
            chk("pc_err", pc_o, m_pc);
            chk("retire_err", retire_cnt_o, m_retire);
            chk("valid_err", inst_valid_o, 0);
            chk("req_err", imem_bus.req, 0);
        end else begin
            m_pc = npc & 32'hFFFF_FFFC;
            chk("valid_acc", inst_valid_o, 0);
            chk("inst_acc", inst_o, NOP_INST);
            chk("pc_acc", pc_o, m_pc);
            chk("retire_acc", retire_cnt_o, m_retire);
            chk("req_next", imem_bus.req, 1);
            chk("addr_next", imem_bus.addr, m_pc);
            chk("misalign_clr", misalign_o, 0);
        end
    endtask

    initial begin
        logic [31:0] rnd_npc;
        rst_n           = 1'b0;
        npc_i           = 32'd0;
        inst_ready_i    = 1'b0;
        imem_bus.gnt    = 1'b0;
        imem_bus.rvalid = 1'b0;
        imem_bus.rdata  = 32'd0;
        m_pc     = RESET_PC;
        m_retire = 32'd0;
        m_err    = 1'b0;

        step();
        step();
        chk("rst_pc", pc_o, RESET_PC);
        chk("rst_inst", inst_o, NOP_INST);
        chk("rst_valid", inst_valid_o, 0);
        chk("rst_req", imem_bus.req, 0);
        chk("rst_retire", retire_cnt_o, 0);
        chk("rst_misalign", misalign_o, 0);

        // release with a stray response in the idle cycle
        rst_n           = 1'b1;
        imem_bus.rvalid = 1'b1;
        imem_bus.rdata  = 32'hDEAD_BEEF;
        #1;
        chk("idle_req", imem_bus.req, 0);
        step();
        imem_bus.rvalid = 1'b0;
        chk("first_req", imem_bus.req, 1);
        chk("first_addr", imem_bus.addr, RESET_PC);
        chk("idle_stray_valid", inst_valid_o, 0);

        // zero-wait fetch
        fetch_one(0, 0, 0, 32'h0050_0093, 32'h0000_0004, 1'b0);
        // gnt withheld, slow memory, backpressure, redirect
        fetch_one(4, 2, 5, $urandom, 32'h0000_0100, 1'b0);
        // retire counter wrap
        fetch_one(1, 1, 1, $urandom, 32'h0000_0200, 1'b1);

        for (int t = 0; t < 25; t++) begin
            rnd_npc = $urandom;
`ifdef IFU_MISALIGN_CHK_EN
            rnd_npc[1:0] = 2'b00;
`endif
            fetch_one(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), $urandom, rnd_npc, 1'b0);
        end

        // reset while waiting for rvalid
        chk("pre_wait_req", imem_bus.req, 1);
        imem_bus.gnt = 1'b1;
        step();
        imem_bus.gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        m_pc     = RESET_PC;
        m_retire = 32'd0;
        chk("midrst_valid", inst_valid_o, 0);
        chk("midrst_pc", pc_o, RESET_PC);
        chk("midrst_retire", retire_cnt_o, 0);
        chk("midrst_req", imem_bus.req, 0);
        step();
        rst_n           = 1'b1;
        imem_bus.rvalid = 1'b1;
        imem_bus.rdata  = 32'hDEAD_BEEF;
        step();
        chk("late_rvalid_valid", inst_valid_o, 0);
        chk("restart_req", imem_bus.req, 1);
        chk("restart_addr", imem_bus.addr, RESET_PC);
        step();
        imem_bus.rvalid = 1'b0;
        chk("late_rvalid_req_valid", inst_valid_o, 0);
        chk("late_rvalid_inst", inst_o, NOP_INST);

        fetch_one(0, 1, 0, 32'h1234_5678, 32'h0000_00FC, 1'b0);
        // misaligned next PC
        fetch_one(0, 0, 1, 32'h0000_0013, 32'h0000_0102, 1'b0);
        for (int i = 0; i < 3; i++) begin
            imem_bus.gnt    = 1'b1;
            imem_bus.rvalid = 1'b1;
            inst_ready_i    = 1'b1;
            step();
            if (m_err) begin
                chk("err_req", imem_bus.req, 0);
                chk("err_valid", inst_valid_o, 0);
                chk("err_sticky", misalign_o, 1);
            end else begin
                chk("nochk_misalign", misalign_o, 0);
            end
        end
        imem_bus.gnt    = 1'b0;
        imem_bus.rvalid = 1'b0;
        inst_ready_i    = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
